// File: rtl/unary_decode_pkg.sv
// Shared types for the unary decode stage.
// Payload struct carried through the skid buffer and count-width helper.
package u_pkg;

  // Widest count field the payload can carry (supports W up to 65535).
  localparam int CNT_MAX_W = 16;

  function automatic int cw(input int w);
    return $clog2(w + 1);
  endfunction

  typedef struct packed {
    logic [CNT_MAX_W-1:0] count;
    logic                 is_compliment;
    logic                 error;
  } unary_dec_t;

  localparam int DEC_W = $bits(unary_dec_t);

endpackage

// File: rtl/unary_decode_skid.sv
// Two-entry valid/ready register slice with a registered in_ready.
// Ports: clk, rst (sync, active high), in_* upstream side, out_* downstream side.
module skid_buffer #(
  parameter int DW = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [DW-1:0] in_data,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [DW-1:0] out_data
);

  logic          skid_full;
  logic [DW-1:0] skid_data;

  logic          out_valid_n;
  logic [DW-1:0] out_data_n;
  logic          skid_full_n;
  logic [DW-1:0] skid_data_n;

  logic          acc;
  logic          emit;

  assign in_ready = ~skid_full;
  assign acc      = in_valid & ~skid_full;
  assign emit     = out_valid & out_ready;

  always_comb begin
    out_valid_n = out_valid;
    out_data_n  = out_data;
    skid_full_n = skid_full;
    skid_data_n = skid_data;
    if (!out_valid || emit) begin
      // Output slot frees up: skid has priority to keep order.
      if (skid_full) begin
        out_valid_n = 1'b1;
        out_data_n  = skid_data;
        skid_full_n = 1'b0;
      end else if (acc) begin
        out_valid_n = 1'b1;
        out_data_n  = in_data;
      end else begin
        out_valid_n = 1'b0;
      end
    end else if (acc) begin
      // Output stalled: park the new beat.
      skid_full_n = 1'b1;
      skid_data_n = in_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      skid_full <= 1'b0;
      skid_data <= '0;
    end else begin
      out_valid <= out_valid_n;
      out_data  <= out_data_n;
      skid_full <= skid_full_n;
      skid_data <= skid_data_n;
    end
  end

endmodule

// File: rtl/unary_decode.sv
// Decodes admitted thermometer codes to binary counts, flags rejects,
// keeps a saturating error count. Ports: i_* inputs, o_* outputs, sync reset.
module unary_decode
  import u_pkg::*;
#(
  parameter int W                     = 16,
  parameter bit P_ADMIT_COMPLIMENT_EN = 1'b1,
  parameter bit P_DROP_ERR            = 1'b0,
  parameter int P_ERR_CNT_W           = 16,
  localparam int CW                   = cw(W)
) (
  input  logic                   i_clk,
  input  logic                   i_rst,
  input  logic                   i_valid,
  output logic                   o_ready,
  input  logic [W-1:0]           i_x,
  input  logic                   i_is_unary,
  input  logic                   i_is_compliment,
  output logic                   o_valid,
  input  logic                   i_ready,
  output logic [CW-1:0]          o_count,
  output logic                   o_is_compliment,
  output logic                   o_error,
  input  logic                   i_err_cnt_clr,
  output logic [P_ERR_CNT_W-1:0] o_err_cnt
);

  localparam logic [P_ERR_CNT_W-1:0] CNT_SAT = '1;

  logic          cmp;
  logic [CW-1:0] ones;
  logic [CW-1:0] zeros;
  logic [CW-1:0] value;
  unary_dec_t    dec;
  unary_dec_t    out_dec;
  logic [DEC_W-1:0] out_raw;
  logic          push;
  logic          err_acc;
  logic          unused_count;

  logic [P_ERR_CNT_W-1:0] err_cnt;

  assign cmp = P_ADMIT_COMPLIMENT_EN & i_is_compliment;

  always_comb begin
    ones = '0;
    for (int i = 0; i < W; i++) begin
      ones = ones + CW'(i_x[i]);
    end
  end

  assign zeros = CW'(W) - ones;
  assign value = cmp ? zeros : ones;

  always_comb begin
    dec = '0;
    dec.error = ~i_is_unary;
    if (i_is_unary) begin
      dec.count[CW-1:0] = value;
      dec.is_compliment = cmp;
    end
  end

  // Dropped error beats never reach the buffer.
  assign push = i_valid & ~(P_DROP_ERR & ~i_is_unary);

  skid_buffer #(
    .DW(DEC_W)
  ) u_skid (
    .clk      (i_clk),
    .rst      (i_rst),
    .in_valid (push),
    .in_ready (o_ready),
    .in_data  (dec),
    .out_valid(o_valid),
    .out_ready(i_ready),
    .out_data (out_raw)
  );

  assign out_dec         = unary_dec_t'(out_raw);
  assign o_count         = out_dec.count[CW-1:0];
  assign o_is_compliment = out_dec.is_compliment;
  assign o_error         = out_dec.error;
  assign unused_count    = ^out_dec.count;

  // Errors count on accept, whether or not they are dropped.
  assign err_acc = i_valid & o_ready & ~i_is_unary;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      err_cnt <= '0;
    end else if (i_err_cnt_clr) begin
      err_cnt <= err_acc ? P_ERR_CNT_W'(1) : '0;
    end else if (err_acc && err_cnt != CNT_SAT) begin
      err_cnt <= err_cnt + P_ERR_CNT_W'(1);
    end
  end

  assign o_err_cnt = err_cnt;

endmodule

// File: tb/tb_unary_decode.sv
// Self-checking bench for unary_decode: queue model plus directed literals.
// Two instances: defaults, and drop-errors / no-compliment / 2-bit counter.
module tb_unary_decode;

  localparam int W = 8;

  typedef struct {
    int cnt;
    bit cmp;
    bit err;
  } beat_t;

  logic       clk;
  logic       i_rst;
  logic       i_valid;
  logic [7:0] i_x;
  logic       i_is_unary;
  logic       i_is_compliment;
  logic       i_ready;
  logic       i_err_cnt_clr;

  logic        o_ready0, o_valid0, o_cmp0, o_err0;
  logic [3:0]  o_count0;
  logic [15:0] o_err_cnt0;
  logic        o_ready1, o_valid1, o_cmp1, o_err1;
  logic [3:0]  o_count1;
  logic [1:0]  o_err_cnt1;

  int checks = 0;
  int failures = 0;
  bit armed = 0;

  beat_t q0[$];
  beat_t q1[$];
  int m0_cnt = 0;
  int m1_cnt = 0;

  unary_decode #(.W(8)) dut0 (
    .i_clk(clk), .i_rst(i_rst), .i_valid(i_valid), .o_ready(o_ready0),
    .i_x(i_x), .i_is_unary(i_is_unary), .i_is_compliment(i_is_compliment),
    .o_valid(o_valid0), .i_ready(i_ready), .o_count(o_count0),
    .o_is_compliment(o_cmp0), .o_error(o_err0),
    .i_err_cnt_clr(i_err_cnt_clr), .o_err_cnt(o_err_cnt0)
  );

  unary_decode #(
    .W(8), .P_ADMIT_COMPLIMENT_EN(1'b0), .P_DROP_ERR(1'b1), .P_ERR_CNT_W(2)
  ) dut1 (
    .i_clk(clk), .i_rst(i_rst), .i_valid(i_valid), .o_ready(o_ready1),
    .i_x(i_x), .i_is_unary(i_is_unary), .i_is_compliment(i_is_compliment),
    .o_valid(o_valid1), .i_ready(i_ready), .o_count(o_count1),
    .o_is_compliment(o_cmp1), .o_error(o_err1),
    .i_err_cnt_clr(i_err_cnt_clr), .o_err_cnt(o_err_cnt1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s act=%0d exp=%0d", nm, act, exp);
    end
  endtask

  function automatic beat_t dec(logic [7:0] x, logic u, logic c, bit en);
    beat_t b;
    b.cnt = 0;
    b.cmp = 0;
    b.err = !u;
    if (u) begin
      b.cmp = c && en;
      b.cnt = b.cmp ? W - $countones(x) : $countones(x);
    end
    return b;
  endfunction

  function automatic int next_cnt(int cur, bit e, bit clr, int mx);
    if (clr) return e ? 1 : 0;
    if (e && cur < mx) return cur + 1;
    return cur;
  endfunction

  // Model: each instance is a FIFO of at most two beats.
  initial begin
    bit a0, a1, e0, e1, er;
    forever begin
      @(posedge clk);
      if (i_rst) begin
        q0.delete();
        q1.delete();
        m0_cnt = 0;
        m1_cnt = 0;
        armed = 1;
      end else if (armed) begin
        er = !i_is_unary;
        a0 = i_valid && q0.size() < 2;
        a1 = i_valid && q1.size() < 2;
        e0 = q0.size() > 0 && i_ready;
        e1 = q1.size() > 0 && i_ready;
        if (e0) void'(q0.pop_front());
        if (e1) void'(q1.pop_front());
        if (a0) q0.push_back(dec(i_x, i_is_unary, i_is_compliment, 1));
        if (a1 && !er) q1.push_back(dec(i_x, i_is_unary, i_is_compliment, 0));
        m0_cnt = next_cnt(m0_cnt, a0 && er, i_err_cnt_clr, 65535);
        m1_cnt = next_cnt(m1_cnt, a1 && er, i_err_cnt_clr, 3);
      end
    end
  end

  // Compare process, away from the active edge.
  initial begin
    forever begin
      @(negedge clk);
      if (armed) begin
        chk("d0_valid", o_valid0, q0.size() > 0);
        chk("d0_ready", o_ready0, q0.size() < 2);
        chk("d0_errcnt", o_err_cnt0, m0_cnt);
        if (q0.size() > 0) begin
          chk("d0_count", o_count0, q0[0].cnt);
          chk("d0_cmp", o_cmp0, q0[0].cmp);
          chk("d0_err", o_err0, q0[0].err);
        end
        chk("d1_valid", o_valid1, q1.size() > 0);
        chk("d1_ready", o_ready1, q1.size() < 2);
        chk("d1_errcnt", o_err_cnt1, m1_cnt);
        if (q1.size() > 0) begin
          chk("d1_count", o_count1, q1[0].cnt);
          chk("d1_cmp", o_cmp1, q1[0].cmp);
          chk("d1_err", o_err1, q1[0].err);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(logic [7:0] x, logic u, logic c);
    i_valid = 1'b1;
    i_x = x;
    i_is_unary = u;
    i_is_compliment = c;
  endtask

  initial begin
    i_rst = 1'b1;
    i_valid = 1'b0;
    i_x = '0;
    i_is_unary = 1'b0;
    i_is_compliment = 1'b0;
    i_ready = 1'b1;
    i_err_cnt_clr = 1'b0;
    tick();
    tick();
    chk("rst_valid", o_valid0, 0);
    chk("rst_ready", o_ready0, 1);
    chk("rst_count", o_count0, 0);
    chk("rst_cmp", o_cmp0, 0);
    chk("rst_err", o_err0, 0);
    chk("rst_errcnt", o_err_cnt0, 0);
    i_rst = 1'b0;

    drive(8'b0000_0111, 1, 0); tick();
    chk("s1_valid", o_valid0, 1);
    chk("s1_count", o_count0, 3);
    chk("s1_cmp", o_cmp0, 0);
    drive(8'b1111_1100, 1, 1); tick();
    chk("s2_count", o_count0, 2);
    chk("s2_cmp", o_cmp0, 1);
    chk("s2_nocmp_count", o_count1, 6);
    chk("s2_nocmp_cmp", o_cmp1, 0);

    drive(8'b0000_0000, 1, 0); tick();
    chk("b_zero", o_count0, 0);
    drive(8'b1111_1111, 1, 1); tick();
    chk("b_ones", o_count0, 0);
    chk("b_ones_cmp", o_cmp0, 1);
    drive(8'b0111_1111, 1, 0); tick();
    chk("b_7f", o_count0, 7);
    drive(8'b1000_0000, 1, 1); tick();
    chk("b_80", o_count0, 7);
    drive(8'b0101_0000, 1, 0); tick();
    chk("incons", o_count0, 2);
    chk("incons_err", o_err0, 0);

    drive(8'b0101_0000, 0, 0); tick();
    chk("e_err", o_err0, 1);
    chk("e_count", o_count0, 0);
    chk("e_errcnt", o_err_cnt0, 1);
    chk("e_drop_valid", o_valid1, 0);
    chk("e_drop_errcnt", o_err_cnt1, 1);
    i_valid = 1'b0; tick();

    i_ready = 1'b0;
    drive(8'b0000_0001, 1, 0); tick();
    chk("bp_ready1", o_ready0, 1);
    drive(8'b0000_0011, 1, 0); tick();
    chk("bp_ready2", o_ready0, 0);
    drive(8'b0000_0111, 1, 0); tick();
    chk("bp_hold1", o_count0, 1);
    drive(8'b0000_1111, 1, 0); tick();
    i_valid = 1'b0;
    chk("bp_hold2", o_count0, 1);
    chk("bp_hold_valid", o_valid0, 1);
    i_ready = 1'b1; tick();
    chk("bp_second", o_count0, 2);
    chk("bp_ready3", o_ready0, 1);
    tick();
    chk("bp_drain", o_valid0, 0);

    for (int k = 0; k < 5; k++) begin
      drive(8'b0101_0000, 0, 0); tick();
    end
    chk("sat_cnt", o_err_cnt1, 3);
    chk("wide_cnt", o_err_cnt0, 6);
    i_err_cnt_clr = 1'b1; tick();
    chk("clr_err", o_err_cnt1, 1);
    i_valid = 1'b0; tick();
    chk("clr_only", o_err_cnt1, 0);
    chk("clr_only0", o_err_cnt0, 0);
    i_err_cnt_clr = 1'b0;
    tick();

    i_ready = 1'b0;
    drive(8'b0101_0000, 0, 0); tick();
    drive(8'b0000_1111, 1, 0); tick();
    chk("full_ready", o_ready0, 0);
    drive(8'b0011_1111, 1, 0);
    i_rst = 1'b1; tick();
    chk("mrst_valid", o_valid0, 0);
    chk("mrst_ready", o_ready0, 1);
    chk("mrst_errcnt", o_err_cnt0, 0);
    chk("mrst_valid1", o_valid1, 0);
    i_rst = 1'b0;
    i_ready = 1'b1;
    drive(8'b0000_0011, 1, 0); tick();
    chk("post_rst", o_count0, 2);
    chk("post_rst_v", o_valid0, 1);
    i_valid = 1'b0;
    tick();
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
